// File: rtl/multicore_shared_ram_if.sv
// Avalon-MM bundle for multicore_shared_ram: NUM_PORTS slave ports, flattened
// per port (port p occupies [p*W +: W] in each vector).
//   master : drives address/byteenable/chipselect/read/write/writedata/lock
//   slave  : drives waitrequest/readdata/readdatavalid
interface multicore_shared_ram_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NUM_PORTS*ADDR_WIDTH-1:0] address;
  logic [NUM_PORTS*BE_WIDTH-1:0]   byteenable;
  logic [NUM_PORTS-1:0]            chipselect;
  logic [NUM_PORTS-1:0]            read;
  logic [NUM_PORTS-1:0]            write;
  logic [NUM_PORTS*DATA_WIDTH-1:0] writedata;
  logic [NUM_PORTS-1:0]            lock;
  logic [NUM_PORTS-1:0]            waitrequest;
  logic [NUM_PORTS*DATA_WIDTH-1:0] readdata;
  logic [NUM_PORTS-1:0]            readdatavalid;

  modport master (
    output address, byteenable, chipselect, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/multicore_shared_ram.sv
// Shared on-chip RAM for NUM_PORTS Nios II cores (mailboxes / shared data).
// One round-robin grant per cycle into a single inferred array; byte-enabled
// writes; reads return one cycle after the grant with readdatavalid.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   clken    : global enable, low = no grants (scheduled readdatavalid still fires)
//   bus      : multicore_shared_ram_if.slave, per-port Avalon-MM signals
// Optional build macro MULTICORE_SHARED_RAM_LOCK_EN: Avalon lock support, a
// granted locked transfer makes that port the sole grantable port until its
// next unlocked granted transfer. Without it, lock is ignored.

// Per-port return path: waitrequest and the read data/valid registers.
module multicore_shared_ram_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  grant,
  input  logic                  rd_grant,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  waitrequest,
  output logic                  readdatavalid,
  output logic [DATA_WIDTH-1:0] readdata
);
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  // The shared read register is only ours during the valid cycle; capture it
  // then so readdata keeps its last value afterwards.
  always_comb begin
    rvalid_d = rd_grant;
    hold_d   = rvalid_q ? rdata : hold_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      hold_q   <= hold_d;
    end
  end

  assign waitrequest   = req & ~grant;
  assign readdatavalid = rvalid_q;
  assign readdata      = rvalid_q ? rdata : hold_q;
endmodule

module multicore_shared_ram #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic clk,
  input logic reset_n,
  input logic clken,
  multicore_shared_ram_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  logic [NUM_PORTS-1:0] req, elig, grant;
  logic                 gnt_any;
  logic [PTR_W-1:0]     gnt_idx, scan_idx;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  int                   idx;

  assign req = bus.chipselect & (bus.read | bus.write);

`ifdef MULTICORE_SHARED_RAM_LOCK_EN
  logic             owner_vld_q, owner_vld_d;
  logic [PTR_W-1:0] owner_q, owner_d;

  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      elig[p] = req[p] & (!owner_vld_q || owner_q == PTR_W'(p));
  end

  // Only the owner can be granted while owned, so any unlocked grant here is
  // the owner's releasing transfer.
  always_comb begin
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    if (gnt_any) begin
      owner_vld_d = bus.lock[gnt_idx];
      if (bus.lock[gnt_idx]) owner_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign elig        = req;
`endif

  // Circular scan starting at rr_ptr; first eligible requester wins.
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    idx      = 0;
    if (clken) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        scan_idx = PTR_W'(idx);
        if (!gnt_any && elig[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any)
      rr_ptr_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end

  // Granted port's command; write wins when read and write are both high.
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [BE_WIDTH-1:0]   g_be;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic                  g_wr, g_rd;

  always_comb begin
    g_addr  = '0;
    g_be    = '0;
    g_wdata = '0;
    g_wr    = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        g_addr  = bus.address[p*ADDR_WIDTH +: ADDR_WIDTH];
        g_be    = bus.byteenable[p*BE_WIDTH +: BE_WIDTH];
        g_wdata = bus.writedata[p*DATA_WIDTH +: DATA_WIDTH];
        g_wr    = bus.write[p];
      end
    end
    g_rd = gnt_any & ~g_wr;
  end

  // Array and its read register are left unreset so they map onto block RAM;
  // the lanes mask rdata_q until a read has actually returned.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (g_wr) begin
      for (int b = 0; b < BE_WIDTH; b++)
        if (g_be[b]) mem[g_addr][b*8 +: 8] <= g_wdata[b*8 +: 8];
    end
    if (g_rd) rdata_q <= mem[g_addr];
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    multicore_shared_ram_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk           (clk),
      .reset_n       (reset_n),
      .req           (req[p]),
      .grant         (grant[p]),
      .rd_grant      (grant[p] & ~bus.write[p]),
      .rdata         (rdata_q),
      .waitrequest   (bus.waitrequest[p]),
      .readdatavalid (bus.readdatavalid[p]),
      .readdata      (bus.readdata[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_multicore_shared_ram.sv
// Directed bench for multicore_shared_ram (4 ports, 32-bit, 1K words).
// Read results are queued per port when a read is granted and compared by a
// monitor when readdatavalid arrives; waitrequest patterns are checked inline.
// Lock scenario is included when MULTICORE_SHARED_RAM_LOCK_EN is defined.
module tb_multicore_shared_ram;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset_n;
  logic clken;
  always #5 clk = ~clk;

  multicore_shared_ram_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  multicore_shared_ram #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .bus     (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q [NP][$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr, input logic lk,
                          input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.chipselect[p]        = rd | wr;
    bus.read[p]              = rd;
    bus.write[p]             = wr;
    bus.lock[p]              = lk;
    bus.address[p*AW +: AW]  = a;
    bus.byteenable[p*4 +: 4] = be;
    bus.writedata[p*DW +: DW] = d;
  endtask

  function automatic logic [31:0] cval(input int p);
    return 32'hC0DE_0000 | p;
  endfunction

  // Lone single-cycle access, called just after a falling edge; returns on the
  // next falling edge with the port idle again.
  task automatic access(input int p, input logic wr, input logic [9:0] a, input logic [3:0] be,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
    set_port(p, !wr, wr, 1'b0, a, be, d);
    #1;
    chk({tag, "_wait"}, bus.waitrequest, 4'b0000);
    if (!wr) exp_q[p].push_back(exp_rd);
    @(negedge clk);
    set_port(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Scoreboard side: every readdatavalid must match the oldest queued entry.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int p = 0; p < NP; p++) begin
        if (bus.readdatavalid[p]) begin
          if (exp_q[p].size() == 0)
            chk($sformatf("unexpected_rdv%0d", p), bus.readdatavalid[p], 1'b0);
          else
            chk($sformatf("rdata%0d", p), bus.readdata[p*DW +: DW], exp_q[p].pop_front());
        end
      end
    end
  end

  initial begin
    logic [3:0] m;
    reset_n = 1'b0;
    clken   = 1'b1;
    bus.address = '0; bus.byteenable = '0; bus.chipselect = '0; bus.read = '0;
    bus.write = '0; bus.writedata = '0; bus.lock = '0;

    repeat (2) @(negedge clk);
    chk("rst_wait",  bus.waitrequest,   4'b0000);
    chk("rst_rdv",   bus.readdatavalid, 4'b0000);
    chk("rst_rdata", bus.readdata,      128'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Write then read from another port
    access(0, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF, '0, "t1_wr");
    access(2, 1'b0, 10'h010, 4'h0, '0, 32'hDEADBEEF, "t1_rd");

    // Byte enables, including an all-zero enable write that must not change data
    access(1, 1'b1, 10'h3FF, 4'hF, 32'h11223344, '0, "t2_wr_full");
    access(1, 1'b1, 10'h3FF, 4'h5, 32'hAABBCCDD, '0, "t2_wr_be5");
    access(3, 1'b0, 10'h3FF, 4'h0, '0, 32'h11BB33DD, "t2_rd");
    access(0, 1'b1, 10'h3FF, 4'h0, 32'hFFFFFFFF, '0, "t2_wr_be0");
    access(3, 1'b0, 10'h3FF, 4'h0, '0, 32'h11BB33DD, "t2_rd_be0");

    // Preload contention and lock addresses
    for (int p = 0; p < NP; p++)
      access(p, 1'b1, 10'h100 + 10'(p), 4'hF, cval(p), '0, "pre_wr");
    access(2, 1'b1, 10'h000, 4'hF, 32'hCAFE0000, '0, "pre_wr0");

    // Reset while a read result is pending cancels it
    set_port(0, 1'b1, 1'b0, 1'b0, 10'h100, 4'h0, '0);
    @(posedge clk); #1;
    chk("mid_rdv_pre", bus.readdatavalid, 4'b0001);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdv",   bus.readdatavalid, 4'b0000);
    chk("mid_rst_rdata", bus.readdata,      128'h0);
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Contention from reset: grants rotate 0,1,2,3,...
    for (int p = 0; p < NP; p++)
      set_port(p, 1'b1, 1'b0, 1'b0, 10'h100 + 10'(p), 4'h0, '0);
    for (int k = 0; k < 8; k++) begin
      #1;
      m = 4'hF & ~(4'b0001 << (k % NP));
      chk($sformatf("rr_wait_c%0d", k), bus.waitrequest, m);
      exp_q[k % NP].push_back(cval(k % NP));
      @(negedge clk);
    end
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Same-cycle write (port 1) and read (port 3) of one address
    @(negedge clk);
    set_port(1, 1'b0, 1'b1, 1'b0, 10'h020, 4'hF, 32'h5A5A5A5A);
    set_port(3, 1'b1, 1'b0, 1'b0, 10'h020, 4'h0, '0);
    #1;
    chk("raw_wait1", bus.waitrequest, 4'b1000);
    @(negedge clk);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("raw_wait2", bus.waitrequest, 4'b0000);
    exp_q[3].push_back(32'h5A5A5A5A);
    @(negedge clk);
    set_port(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // clken low for 3 cycles; the read granted just before still returns
    access(3, 1'b0, 10'h020, 4'h0, '0, 32'h5A5A5A5A, "ck_pre_rd");
    clken = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, 10'h010, 4'h0, '0);
    set_port(2, 1'b1, 1'b0, 1'b0, 10'h3FF, 4'h0, '0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ck_off_wait%0d", k), bus.waitrequest, 4'b0101);
      @(negedge clk);
    end
    clken = 1'b1;
    #1;
    chk("ck_on_wait0", bus.waitrequest, 4'b0100);
    exp_q[0].push_back(32'hDEADBEEF);
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("ck_on_wait2", bus.waitrequest, 4'b0000);
    exp_q[2].push_back(32'h11BB33DD);
    @(negedge clk);
    set_port(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("hold_rdv",    bus.readdatavalid,    4'b0000);
    chk("hold_rdata3", bus.readdata[96 +: 32], 32'h5A5A5A5A);
    chk("hold_rdata2", bus.readdata[64 +: 32], 32'h11BB33DD);

`ifdef MULTICORE_SHARED_RAM_LOCK_EN
    // Locked read by port 1, port 0 shut out until port 1's unlocked write
    set_port(1, 1'b1, 1'b0, 1'b1, 10'h000, 4'h0, '0);
    #1;
    chk("lk_wait1", bus.waitrequest, 4'b0000);
    exp_q[1].push_back(32'hCAFE0000);
    @(negedge clk);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_port(0, 1'b1, 1'b0, 1'b0, 10'h100, 4'h0, '0);
    #1;
    chk("lk_wait2", bus.waitrequest, 4'b0001);
    @(negedge clk);
    set_port(1, 1'b0, 1'b1, 1'b0, 10'h000, 4'hF, 32'h00000001);
    #1;
    chk("lk_wait3", bus.waitrequest, 4'b0001);
    @(negedge clk);
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("lk_wait4", bus.waitrequest, 4'b0000);
    exp_q[0].push_back(cval(0));
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    access(2, 1'b0, 10'h000, 4'h0, '0, 32'h00000001, "lk_final_rd");
`endif

    @(negedge clk);
    chk("queues_drained",
        exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
